gcd_req_arbiter: RTL



---
 rtl/gcd_pkg.sv | 18 +
 rtl/gcd_req_arbiter_if.sv | 45 ++++
 rtl/gcd_rr_arb2.sv | 25 ++
 rtl/gcd_req_arbiter.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/gcd_pkg.sv
// Shared definitions for the GCD request arbiter.
// Contents: default widths, FSM state encoding, requester id constants.
package gcd_pkg;

   localparam int unsigned DATA_W_DEF = 5;
   localparam int unsigned CNT_W_DEF  = 8;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      LAUNCH  = 2'd1,
      WAIT    = 2'd2,
      DELIVER = 2'd3
   } state_e;

   localparam logic REQ0 = 1'b0;
   localparam logic REQ1 = 1'b1;

endpackage

// File: rtl/gcd_req_arbiter_if.sv
// Bundle of requester, response and engine-side signals of the GCD arbiter.
// slave  : arbiter view (drives ready/valid pulses, response and engine strobes)
// master : environment view (requesters, consumers and the GCD engine)
interface gcd_req_arbiter_if
   import gcd_pkg::*;
#(
   parameter int unsigned DATA_W = DATA_W_DEF,
   parameter int unsigned CNT_W  = CNT_W_DEF
);
   logic              Req0_valid;
   logic [DATA_W-1:0] Req0_A;
   logic [DATA_W-1:0] Req0_B;
   logic              Req0_ready;
   logic              Req1_valid;
   logic [DATA_W-1:0] Req1_A;
   logic [DATA_W-1:0] Req1_B;
   logic              Req1_ready;
   logic              Rsp0_valid;
   logic              Rsp1_valid;
   logic [1:0]        Rsp_taken;
   logic [DATA_W-1:0] Rsp_data;
   logic [CNT_W-1:0]  Rsp_cycles;
   logic [DATA_W-1:0] Eng_A;
   logic [DATA_W-1:0] Eng_B;
   logic              Eng_In_ready;
   logic              Eng_Done;
   logic [DATA_W-1:0] Eng_Result;
   logic              Eng_Result_taken;
   logic              Busy;

   modport slave (
      input  Req0_valid, Req0_A, Req0_B, Req1_valid, Req1_A, Req1_B,
             Rsp_taken, Eng_Done, Eng_Result,
      output Req0_ready, Req1_ready, Rsp0_valid, Rsp1_valid, Rsp_data,
             Rsp_cycles, Eng_A, Eng_B, Eng_In_ready, Eng_Result_taken, Busy
   );

   modport master (
      output Req0_valid, Req0_A, Req0_B, Req1_valid, Req1_A, Req1_B,
             Rsp_taken, Eng_Done, Eng_Result,
      input  Req0_ready, Req1_ready, Rsp0_valid, Rsp1_valid, Rsp_data,
             Rsp_cycles, Eng_A, Eng_B, Eng_In_ready, Eng_Result_taken, Busy
   );

endinterface

// File: rtl/gcd_rr_arb2.sv
// Combinational two-way round-robin grant.
// valid0/valid1 : request levels; rr_last : id of the last served requester
// grant_valid_c : some request is present; grant_id_c : winning requester id
module gcd_rr_arb2
   import gcd_pkg::*;
(
   input  logic valid0,
   input  logic valid1,
   input  logic rr_last,
   output logic grant_valid_c,
   output logic grant_id_c
);

   // On contention the requester not served last wins.
   always_comb begin
      grant_valid_c = valid0 | valid1;
      grant_id_c    = REQ0;
      if (valid0 && valid1) begin
         grant_id_c = ~rr_last;
      end else if (valid1) begin
         grant_id_c = REQ1;
      end
   end

endmodule

// File: rtl/gcd_req_arbiter.sv
// Shares one GCD engine between two requesters with round-robin arbitration,
// returning the result and the measured engine latency to the granted side.
// Clk  : rising-edge clock
// nrst : asynchronous active-low reset (shared with the engine)
// bus  : requester / response / engine signals (slave modport)
module gcd_req_arbiter
   import gcd_pkg::*;
#(
   parameter int unsigned DATA_W = DATA_W_DEF,
   parameter int unsigned CNT_W  = CNT_W_DEF
)(
   input  logic                Clk,
   input  logic                nrst,
   gcd_req_arbiter_if.slave    bus
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_e            state_q, state_d;
   logic              rr_last_q, rr_last_d;
   logic              gid_q, gid_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [DATA_W-1:0] eng_a_q, eng_a_d;
   logic [DATA_W-1:0] eng_b_q, eng_b_d;
   logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
   logic [CNT_W-1:0]  rsp_cycles_q, rsp_cycles_d;
   logic              req0_ready_q, req0_ready_d;
   logic              req1_ready_q, req1_ready_d;
   logic              rsp0_valid_q, rsp0_valid_d;
   logic              rsp1_valid_q, rsp1_valid_d;
   logic              in_ready_q, in_ready_d;
   logic              taken_q, taken_d;
   logic              busy_q, busy_d;
   logic              grant_valid_c;
   logic              grant_id_c;

   gcd_rr_arb2 u_arb (
      .valid0        (bus.Req0_valid),
      .valid1        (bus.Req1_valid),
      .rr_last       (rr_last_q),
      .grant_valid_c (grant_valid_c),
      .grant_id_c    (grant_id_c)
   );

   // Next-state and registered-output computation.
   always_comb begin
      state_d      = state_q;
      rr_last_d    = rr_last_q;
      gid_d        = gid_q;
      cnt_d        = cnt_q;
      eng_a_d      = eng_a_q;
      eng_b_d      = eng_b_q;
      rsp_data_d   = rsp_data_q;
      rsp_cycles_d = rsp_cycles_q;
      req0_ready_d = 1'b0;
      req1_ready_d = 1'b0;
      rsp0_valid_d = rsp0_valid_q;
      rsp1_valid_d = rsp1_valid_q;
      in_ready_d   = 1'b0;
      taken_d      = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (grant_valid_c) begin
               gid_d   = grant_id_c;
               state_d = LAUNCH;
               if (grant_id_c == REQ0) begin
                  req0_ready_d = 1'b1;
                  eng_a_d      = bus.Req0_A;
                  eng_b_d      = bus.Req0_B;
               end else begin
                  req1_ready_d = 1'b1;
                  eng_a_d      = bus.Req1_A;
                  eng_b_d      = bus.Req1_B;
               end
            end
         end
         LAUNCH: begin
            // Counter reads 0 in the cycle the engine strobe is visible.
            in_ready_d = 1'b1;
            cnt_d      = '0;
            state_d    = WAIT;
         end
         WAIT: begin
            cnt_d = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + CNT_W'(1);
            if (bus.Eng_Done) begin
               rsp_data_d   = bus.Eng_Result;
               rsp_cycles_d = cnt_q;
               taken_d      = 1'b1;
               state_d      = DELIVER;
               if (gid_q == REQ0) begin
                  rsp0_valid_d = 1'b1;
               end else begin
                  rsp1_valid_d = 1'b1;
               end
            end
         end
         DELIVER: begin
            if (bus.Rsp_taken[gid_q]) begin
               rsp0_valid_d = 1'b0;
               rsp1_valid_d = 1'b0;
               rr_last_d    = gid_q;
               state_d      = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      busy_d = (state_d != IDLE);
   end

   // State and output registers; rr_last resets to REQ1 so REQ0 wins first.
   always_ff @(posedge Clk or negedge nrst) begin
      if (!nrst) begin
         state_q      <= IDLE;
         rr_last_q    <= REQ1;
         gid_q        <= REQ0;
         cnt_q        <= '0;
         eng_a_q      <= '0;
         eng_b_q      <= '0;
         rsp_data_q   <= '0;
         rsp_cycles_q <= '0;
         req0_ready_q <= 1'b0;
         req1_ready_q <= 1'b0;
         rsp0_valid_q <= 1'b0;
         rsp1_valid_q <= 1'b0;
         in_ready_q   <= 1'b0;
         taken_q      <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         rr_last_q    <= rr_last_d;
         gid_q        <= gid_d;
         cnt_q        <= cnt_d;
         eng_a_q      <= eng_a_d;
         eng_b_q      <= eng_b_d;
         rsp_data_q   <= rsp_data_d;
         rsp_cycles_q <= rsp_cycles_d;
         req0_ready_q <= req0_ready_d;
         req1_ready_q <= req1_ready_d;
         rsp0_valid_q <= rsp0_valid_d;
         rsp1_valid_q <= rsp1_valid_d;
         in_ready_q   <= in_ready_d;
         taken_q      <= taken_d;
         busy_q       <= busy_d;
      end
   end

   assign bus.Req0_ready       = req0_ready_q;
   assign bus.Req1_ready       = req1_ready_q;
   assign bus.Rsp0_valid       = rsp0_valid_q;
   assign bus.Rsp1_valid       = rsp1_valid_q;
   assign bus.Rsp_data         = rsp_data_q;
   assign bus.Rsp_cycles       = rsp_cycles_q;
   assign bus.Eng_A            = eng_a_q;
   assign bus.Eng_B            = eng_b_q;
   assign bus.Eng_In_ready     = in_ready_q;
   assign bus.Eng_Result_taken = taken_q;
   assign bus.Busy             = busy_q;

endmodule
